frame_difference_ctrl: RTL and testbench
========================================

Name: frame_difference_ctrl

Overview:
- Sequences the frame-difference datapath.
- Monitors the paired-frame AXI4-Stream video bus (tuser = SOF, tlast = EOL) and drives the datapath's `ce` mode select (0 = pass current frame, 1 = absolute difference).
- Changes `ce` only on frame boundaries, holds off difference mode for a configurable number of priming frames after enable, and flags stream geometry errors.
- Sits beside the datapath, sharing its input handshake; register control comes from the AXI-Lite config block.

Parameters:
- FRAME_WIDTH, 640, active pixels per line (beats between EOLs).
- FRAME_HEIGHT, 480, lines per frame.
- CNT_W, 12, width of the pixel and line counters; must satisfy 2^CNT_W > max(FRAME_WIDTH, FRAME_HEIGHT).
- PRIME_FRAMES, 1, complete frames passed through in mode 0 after enable before difference mode starts; legal range 1..15.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable_req  in  1  level request for difference mode (from config register)
- err_clr  in  1  single-cycle pulse; clears sticky error flags
- mon_tvalid  in  1  tvalid of the datapath input stream
- mon_tready  in  1  tready of the datapath input stream
- mon_tuser  in  1  SOF marker
- mon_tlast  in  1  EOL marker
- ce  out  1  datapath mode select, registered
- state  out  2  current FSM state (IDLE=0, SYNC=1, PRIME=2, RUN=3)
- frame_count  out  16  completed frames while in RUN
- err_sof_early  out  1  sticky: SOF arrived mid-frame
- err_line_len  out  1  sticky: EOL at wrong pixel count

Behaviour:
- Beat definitions:
  - A beat is a cycle with mon_tvalid & mon_tready.
  - EOF beat = beat with mon_tlast=1 and line counter y == FRAME_HEIGHT-1.
- Reset values (aresetn low, asynchronous): ce=0, state=IDLE, frame_count=0, both error flags 0, x=0, y=0, prime counter=0. Reset mid-frame abandons the frame; after release, counters start from 0 and the FSM is IDLE.
- Counters (update on beats only):
  - Beat with mon_tuser=1: if x!=0 or y!=0, set err_sof_early. In all cases restart: x=1, y=0, or x=0, y=1 if mon_tlast is also 1.
  - Beat with mon_tlast=1: if (x+1) != FRAME_WIDTH, set err_line_len. Then x=0; y=y+1, wrapping to 0 on an EOF beat.
  - Other beats: x=x+1, saturating at 2^CNT_W-1.
- FSM (transitions registered; ce is a registered function of next state, so a new ce value appears the cycle after the EOF beat and is stable for the whole following frame, including its SOF beat):
  - IDLE: ce=0. Goes to SYNC when enable_req=1.
  - SYNC: ce=0. Waits for an EOF beat, then goes to PRIME with prime counter=0. Goes to IDLE if enable_req=0.
  - PRIME: ce=0. Each EOF beat increments the prime counter. On the EOF beat where count+1 == PRIME_FRAMES, goes to RUN with ce=1. Goes to IDLE immediately if enable_req=0.
  - RUN: ce=1. Each EOF beat increments frame_count (wraps 0xFFFF to 0). If enable_req=0 at the EOF beat, goes to IDLE and ce=0 from the next cycle. enable_req dropping mid-frame does not change ce before EOF.
- Simultaneous events: if enable_req=0 and an EOF beat occur in the same cycle in PRIME, the FSM goes to IDLE. err_clr in the same cycle as a new error: the set wins.
- An SOF-early restart does not count as an EOF and causes no FSM transition.
- mon_tvalid without mon_tready, or vice versa, has no effect.
- Latency: ce switches exactly 1 clock after the qualifying EOF beat.

Test Plan:
- Bench uses FRAME_WIDTH=4, FRAME_HEIGHT=2, PRIME_FRAMES=1.
- Reset, then stream 3 well-formed frames (8 beats each) with enable_req=0 -> ce=0 throughout, state=0, frame_count=0, no errors.
- enable_req=1 two beats into frame 0 -> SYNC until frame 0 EOF; PRIME during frame 1; ce=1 from the cycle after frame 1 EOF. Frame 2 SOF beat sees ce=1; frame_count=1 after frame 2 EOF.
- In RUN, drop enable_req at beat 3 of a frame -> ce stays 1 until that frame's EOF beat, ce=0 the next cycle, state=0.
- Insert tvalid=1/tready=0 stalls of 5 cycles at the EOF beat -> no state change until the handshake completes, then ce switches 1 cycle later.
- Send an EOL after 3 beats -> err_line_len=1 and stays set. Send SOF at x=2, y=1 -> err_sof_early=1 and counters restart. Pulse err_clr -> both flags 0 next cycle.
- Assert aresetn low mid-frame while in RUN -> ce=0 and state=0 immediately (asynchronously); frame_count=0.

Source files
------------

// File: rtl/frame_difference_ctrl.sv
// Frame-difference sequencer: tracks stream geometry and switches the
// datapath between pass-through and difference mode on frame boundaries.
module frame_difference_ctrl #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CNT_W        = 12,
    parameter int PRIME_FRAMES = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable_req,
    input  logic        err_clr,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tuser,
    input  logic        mon_tlast,
    output logic        ce,
    output logic [1:0]  state,
    output logic [15:0] frame_count,
    output logic        err_sof_early,
    output logic        err_line_len
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [CNT_W:0]   W_LEN  = (CNT_W+1)'(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(FRAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0] X_MAX  = '1;
    localparam logic [3:0]       P_LAST = 4'(PRIME_FRAMES - 1);

    state_t         st;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [3:0]     pcnt;
    logic           beat;
    logic           eof;
    logic [CNT_W:0] line_len;
    logic           sof_bad;
    logic           len_bad;

    // An SOF beat begins a new line, so its own length is measured from 0.
    always_comb begin
        beat     = mon_tvalid & mon_tready;
        eof      = beat & mon_tlast & (y == H_LAST);
        line_len = mon_tuser ? (CNT_W+1)'(1) : {1'b0, x} + 1'b1;
        sof_bad  = beat & mon_tuser & ((x != '0) | (y != '0));
        len_bad  = beat & mon_tlast & (line_len != W_LEN);
    end

    // Pixel and line position, advanced on handshake beats only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
        end else if (beat) begin
            if (mon_tuser) begin
                x <= mon_tlast ? '0 : CNT_W'(1);
                y <= mon_tlast ? CNT_W'(1) : '0;
            end else if (mon_tlast) begin
                x <= '0;
                y <= (y == H_LAST) ? '0 : y + 1'b1;
            end else if (x != X_MAX) begin
                x <= x + 1'b1;
            end
        end
    end

    // Sticky geometry errors; a new error wins over a clear in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_sof_early <= 1'b0;
            err_line_len  <= 1'b0;
        end else begin
            err_sof_early <= sof_bad | (err_sof_early & ~err_clr);
            err_line_len  <= len_bad | (err_line_len & ~err_clr);
        end
    end

    // Mode sequencer; ce only ever changes together with an EOF transition.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st          <= IDLE;
            ce          <= 1'b0;
            pcnt        <= '0;
            frame_count <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    ce <= 1'b0;
                    if (enable_req) st <= SYNC;
                end
                SYNC: begin
                    ce <= 1'b0;
                    if (!enable_req) begin
                        st <= IDLE;
                    end else if (eof) begin
                        st   <= PRIME;
                        pcnt <= '0;
                    end
                end
                PRIME: begin
                    if (!enable_req) begin
                        st <= IDLE;
                        ce <= 1'b0;
                    end else if (eof) begin
                        if (pcnt == P_LAST) begin
                            st <= RUN;
                            ce <= 1'b1;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (eof) begin
                        frame_count <= frame_count + 16'd1;
                        if (!enable_req) begin
                            st <= IDLE;
                            ce <= 1'b0;
                        end
                    end
                end
                default: begin
                    st <= IDLE;
                    ce <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_frame_difference_ctrl.sv
// Directed bench for frame_difference_ctrl with a 4x2 frame and one
// priming frame.
module tb_frame_difference_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable_req = 1'b0;
    logic        err_clr = 1'b0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_tuser = 1'b0;
    logic        mon_tlast = 1'b0;
    logic        ce;
    logic [1:0]  state;
    logic [15:0] frame_count;
    logic        err_sof_early;
    logic        err_line_len;

    int checks = 0;
    int failures = 0;

    frame_difference_ctrl #(
        .FRAME_WIDTH (4),
        .FRAME_HEIGHT(2),
        .CNT_W       (12),
        .PRIME_FRAMES(1)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable_req   (enable_req),
        .err_clr      (err_clr),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tuser    (mon_tuser),
        .mon_tlast    (mon_tlast),
        .ce           (ce),
        .state        (state),
        .frame_count  (frame_count),
        .err_sof_early(err_sof_early),
        .err_line_len (err_line_len)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sof, input logic eol);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = sof;
        mon_tlast  = eol;
        @(posedge aclk);
        #1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic frame();
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_ce", 16'(ce), 16'd0);
        check("rst_state", 16'(state), 16'd0);
        check("rst_fc", frame_count, 16'd0);
        check("rst_errs", 16'({err_sof_early, err_line_len}), 16'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // disabled: three clean frames stay in pass mode
        for (int f = 0; f < 3; f++) begin
            frame();
            check("dis_ce", 16'(ce), 16'd0);
            check("dis_state", 16'(state), 16'd0);
        end
        check("dis_fc", frame_count, 16'd0);
        check("dis_errs", 16'({err_sof_early, err_line_len}), 16'd0);

        // enable two beats into frame 0
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        enable_req = 1'b1;
        beat(1'b0, 1'b0);
        check("sync_state", 16'(state), 16'd1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("sync_hold", 16'(state), 16'd1);
        beat(1'b0, 1'b1);
        check("prime_state", 16'(state), 16'd2);
        check("prime_ce", 16'(ce), 16'd0);

        // frame 1 primes, then difference mode
        beat(1'b1, 1'b0);
        check("prime_sof_ce", 16'(ce), 16'd0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("prime_pre_eof_ce", 16'(ce), 16'd0);
        beat(1'b0, 1'b1);
        check("run_state", 16'(state), 16'd3);
        check("run_ce", 16'(ce), 16'd1);
        check("run_fc0", frame_count, 16'd0);

        // frame 2 in RUN
        frame();
        check("run_fc1", frame_count, 16'd1);
        check("run_ce2", 16'(ce), 16'd1);

        // drop enable mid-frame, stall the EOF beat
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        enable_req = 1'b0;
        beat(1'b0, 1'b1);
        check("drop_ce", 16'(ce), 16'd1);
        check("drop_state", 16'(state), 16'd3);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("drop_ce2", 16'(ce), 16'd1);
        mon_tvalid = 1'b1;
        mon_tready = 1'b0;
        mon_tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            check("stall_state", 16'(state), 16'd3);
            check("stall_ce", 16'(ce), 16'd1);
        end
        mon_tready = 1'b1;
        @(posedge aclk);
        #1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        check("stop_ce", 16'(ce), 16'd0);
        check("stop_state", 16'(state), 16'd0);
        check("stop_fc", frame_count, 16'd2);
        check("stop_errs", 16'({err_sof_early, err_line_len}), 16'd0);

        // short line, then early SOF at x=2 y=1
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        check("len_err", 16'(err_line_len), 16'd1);
        check("len_sof_ok", 16'(err_sof_early), 16'd0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("len_sticky", 16'(err_line_len), 16'd1);
        beat(1'b1, 1'b0);
        check("sof_err", 16'(err_sof_early), 16'd1);
        check("sof_state", 16'(state), 16'd0);
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        check("clr_errs", 16'({err_sof_early, err_line_len}), 16'd0);

        // counters restarted at x=1 y=0: finish this frame cleanly
        enable_req = 1'b1;
        beat(1'b0, 1'b0);
        check("re_sync", 16'(state), 16'd1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        check("re_prime", 16'(state), 16'd2);
        check("re_errs", 16'({err_sof_early, err_line_len}), 16'd0);
        frame();
        check("re_run", 16'(state), 16'd3);
        check("re_ce", 16'(ce), 16'd1);

        // asynchronous reset mid-frame
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        check("arst_ce", 16'(ce), 16'd0);
        check("arst_state", 16'(state), 16'd0);
        check("arst_fc", frame_count, 16'd0);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_sync", 16'(state), 16'd1);
        frame();
        check("post_prime", 16'(state), 16'd2);
        check("post_errs", 16'({err_sof_early, err_line_len}), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
